// File: rtl/gaussian_conv_if.sv
// Output pixel stream from gaussian_conv towards the output image SRAM writer.
// master drives pixel/origin/valid, slave returns ready.
interface gaussian_conv_if #(
  parameter int unsigned PIXEL_DEPTH = 8,
  parameter int unsigned X_W         = 6,
  parameter int unsigned Y_W         = 6
);
  logic [PIXEL_DEPTH-1:0] out_pixel;
  logic [X_W-1:0]         out_x;
  logic [Y_W-1:0]         out_y;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output out_pixel, out_x, out_y, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_pixel, out_x, out_y, out_valid,
    output out_ready
  );
endinterface

// File: rtl/gaussian_conv.sv
// Sliding-window convolution: one weight tap per cycle against the latched window, then
// round/saturate and hand one pixel per window to the output stream.
module gaussian_conv #(
  parameter int unsigned MAX_KERNAL   = 31,
  parameter int unsigned X_MAX        = 60,
  parameter int unsigned Y_MAX        = 60,
  parameter int unsigned PIXEL_DEPTH  = 8,
  parameter int unsigned WEIGHT_DEPTH = 8,
  parameter int unsigned NORM_SHIFT   = 8
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        start,
  input  logic [7:0]                                  kernel_size,
  input  logic                                        new_sample_ready,
  input  logic [MAX_KERNAL*MAX_KERNAL*PIXEL_DEPTH-1:0] working_memory,
  output logic                                        new_trans,
  output logic                                        new_sample_req,
  input  logic [$clog2(X_MAX)-1:0]                    curr_x,
  input  logic [$clog2(Y_MAX)-1:0]                    curr_y,
  input  logic                                        end_pos,
  output logic                                        update_pos,
  output logic [$clog2(MAX_KERNAL*MAX_KERNAL)-1:0]    w_addr,
  output logic                                        w_ren,
  input  logic [WEIGHT_DEPTH-1:0]                     w_rdat,
  gaussian_conv_if.master                             out_if,
  output logic                                        done
);
  localparam int unsigned KW     = $clog2(MAX_KERNAL + 1);
  localparam int unsigned AW     = $clog2(MAX_KERNAL * MAX_KERNAL);
  localparam int unsigned ACC_W  = PIXEL_DEPTH + WEIGHT_DEPTH + AW;
  localparam int unsigned WM_W   = MAX_KERNAL * MAX_KERNAL * PIXEL_DEPTH;
  localparam int unsigned PW     = $clog2(WM_W);
  localparam int unsigned XW     = $clog2(X_MAX);
  localparam int unsigned YW     = $clog2(Y_MAX);
  localparam int unsigned PixMax = 2 ** PIXEL_DEPTH - 1;
  localparam logic [ACC_W:0] RndHalf = (ACC_W + 1)'(1) << (NORM_SHIFT - 1);

  typedef enum logic [2:0] {
    StIdle, StTrans, StWait, StReq, StMac, StRnd, StOut, StFin
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d, k_clamped;
  logic [KW-1:0]          x_q, x_d, y_q, y_d;
  logic [KW-1:0]          px_q, px_d, py_q, py_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   issue_q, issue_d, pend_q, pend_d;
  logic [ACC_W-1:0]       acc_q, acc_d, mac_prod;
  logic [PIXEL_DEPTH-1:0] pix_q, pix_d, pix_sel, rnd_pix;
  logic [XW-1:0]          ox_q, ox_d;
  logic [YW-1:0]          oy_q, oy_d;
  logic [PW-1:0]          pix_base;
  logic [ACC_W:0]         rnd_sum, rnd_shift;
  logic                   out_valid;

  always_comb begin
    if (kernel_size == 8'd0) begin
      k_clamped = KW'(1);
    end else if (32'(kernel_size) > MAX_KERNAL) begin
      k_clamped = KW'(MAX_KERNAL);
    end else begin
      k_clamped = KW'(kernel_size);
    end
  end

  // Window is packed x-major: pixel [x][y] sits at bit ((x*MAX_KERNAL)+y)*PIXEL_DEPTH.
  // px/py trail the issued tap by one cycle to line up with w_rdat.
  always_comb begin
    pix_base = PW'((32'(px_q) * MAX_KERNAL + 32'(py_q)) * PIXEL_DEPTH);
    pix_sel  = working_memory[pix_base +: PIXEL_DEPTH];
    mac_prod = ACC_W'(pix_sel) * ACC_W'(w_rdat);
  end

  always_comb begin
    rnd_sum   = {1'b0, acc_q} + RndHalf;
    rnd_shift = rnd_sum >> NORM_SHIFT;
    if (rnd_shift > (ACC_W + 1)'(PixMax)) begin
      rnd_pix = '1;
    end else begin
      rnd_pix = rnd_shift[PIXEL_DEPTH-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    x_d            = x_q;
    y_d            = y_q;
    px_d           = px_q;
    py_d           = py_q;
    addr_d         = addr_q;
    issue_d        = issue_q;
    pend_d         = pend_q;
    acc_d          = acc_q;
    pix_d          = pix_q;
    ox_d           = ox_q;
    oy_d           = oy_q;
    new_trans      = 1'b0;
    new_sample_req = 1'b0;
    update_pos     = 1'b0;
    w_ren          = 1'b0;
    w_addr         = '0;
    done           = 1'b0;
    out_valid      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d     = k_clamped;
          state_d = StTrans;
        end
      end
      StTrans: begin
        new_trans = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (new_sample_ready) state_d = StReq;
      end
      StReq: begin
        new_sample_req = 1'b1;
        ox_d           = curr_x;
        oy_d           = curr_y;
        acc_d          = '0;
        x_d            = '0;
        y_d            = '0;
        addr_d         = '0;
        issue_d        = 1'b1;
        pend_d         = 1'b0;
        state_d        = StMac;
      end
      StMac: begin
        if (issue_q) begin
          w_ren  = 1'b1;
          w_addr = addr_q;
          addr_d = addr_q + AW'(1);
          px_d   = x_q;
          py_d   = y_q;
          if (x_q == k_q - KW'(1)) begin
            x_d = '0;
            if (y_q == k_q - KW'(1)) begin
              issue_d = 1'b0;
            end else begin
              y_d = y_q + KW'(1);
            end
          end else begin
            x_d = x_q + KW'(1);
          end
        end
        pend_d = issue_q;
        if (pend_q) acc_d = acc_q + mac_prod;
        // First non-issuing cycle folds in the final tap.
        if (!issue_q) state_d = StRnd;
      end
      StRnd: begin
        pix_d   = rnd_pix;
        state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_if.out_ready) begin
          if (end_pos) begin
            state_d = StFin;
          end else begin
            update_pos = 1'b1;
            state_d    = StWait;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      addr_q  <= '0;
      issue_q <= 1'b0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
      pix_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_pixel = pix_q;
  assign out_if.out_x     = ox_q;
  assign out_if.out_y     = oy_q;

endmodule

// File: tb/tb_gaussian_conv.sv
// Bench for gaussian_conv: drives conv_memory / pixel_pos / weight SRAM roles, scoreboards
// expected pixels and checks latency, tap addressing, back-pressure and reset behaviour.
module tb_gaussian_conv;
  localparam int unsigned MK   = 31;
  localparam int unsigned PD   = 8;
  localparam int unsigned WM_W = MK * MK * PD;

  typedef struct packed {
    logic [7:0] pix;
    logic [5:0] x;
    logic [5:0] y;
  } exp_t;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            start;
  logic [7:0]      kernel_size;
  logic            new_sample_ready;
  logic [WM_W-1:0] working_memory;
  logic            new_trans;
  logic            new_sample_req;
  logic [5:0]      curr_x;
  logic [5:0]      curr_y;
  logic            end_pos;
  logic            update_pos;
  logic [9:0]      w_addr;
  logic            w_ren;
  logic [7:0]      w_rdat = 8'd0;
  logic            done;

  gaussian_conv_if #(.PIXEL_DEPTH(8), .X_W(6), .Y_W(6)) out_if ();

  gaussian_conv dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .kernel_size      (kernel_size),
    .new_sample_ready (new_sample_ready),
    .working_memory   (working_memory),
    .new_trans        (new_trans),
    .new_sample_req   (new_sample_req),
    .curr_x           (curr_x),
    .curr_y           (curr_y),
    .end_pos          (end_pos),
    .update_pos       (update_pos),
    .w_addr           (w_addr),
    .w_ren            (w_ren),
    .w_rdat           (w_rdat),
    .out_if           (out_if),
    .done             (done)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   bad_addr = 0;
  int   wt_m [MK*MK];
  int   pix_m [MK][MK];
  int   addr_log [$];
  exp_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Weight SRAM: one-cycle read latency; also logs issued tap addresses.
  always @(posedge clk) begin
    if (w_ren) begin
      w_rdat <= 8'(wt_m[w_addr]);
      addr_log.push_back(int'(w_addr));
    end else if (w_addr != 10'd0) begin
      bad_addr <= bad_addr + 1;
    end
  end

  function automatic int model_pixel(input int k);
    longint acc = 0;
    longint r;
    for (int y = 0; y < k; y++)
      for (int x = 0; x < k; x++)
        acc += longint'(pix_m[x][y]) * longint'(wt_m[y*k + x]);
    r = (acc + 128) >> 8;
    return (r > 255) ? 255 : int'(r);
  endfunction

  task automatic fill_pix(input int v, input bit rnd);
    for (int x = 0; x < MK; x++)
      for (int y = 0; y < MK; y++)
        pix_m[x][y] = rnd ? int'($urandom_range(255)) : v;
  endtask

  task automatic fill_wt(input int v, input bit rnd);
    for (int i = 0; i < MK*MK; i++) wt_m[i] = rnd ? int'($urandom_range(v)) : v;
  endtask

  task automatic pack_window();
    for (int x = 0; x < MK; x++)
      for (int y = 0; y < MK; y++)
        working_memory[(x*MK + y)*PD +: PD] = 8'(pix_m[x][y]);
  endtask

  task automatic push_expected(input int k, input int x, input int y);
    exp_t e;
    e.pix = 8'(model_pixel(k));
    e.x   = 6'(x);
    e.y   = 6'(y);
    sb.push_back(e);
  endtask

  task automatic hard_reset();
    start = 1'b0;
    new_sample_ready = 1'b0;
    end_pos = 1'b0;
    kernel_size = 8'd0;
    out_if.out_ready = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    sb.delete();
    addr_log.delete();
  endtask

  task automatic start_frame(input int ks, output logic nt);
    kernel_size = 8'(ks);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nt = new_trans;
  endtask

  // Offers a window, returns the cycle new_sample_req was seen and the first out_valid cycle.
  task automatic serve_window(input int x, input int y, input logic last,
                              output int t_req, output int t_out, output bit to);
    curr_x = 6'(x);
    curr_y = 6'(y);
    end_pos = last;
    new_sample_ready = 1'b1;
    t_req = -1;
    t_out = -1;
    to = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (new_sample_req) begin
        t_req = cyc;
        break;
      end
    end
    new_sample_ready = 1'b0;
    if (t_req < 0) begin
      to = 1'b1;
      return;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (out_if.out_valid) begin
        t_out = cyc;
        break;
      end
    end
    if (t_out < 0) to = 1'b1;
  endtask

  task automatic accept_out(output logic upd, output logic dn);
    out_if.out_ready = 1'b1;
    #1;
    upd = update_pos;
    @(negedge clk);
    out_if.out_ready = 1'b0;
    dn = done;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({new_trans, new_sample_req, update_pos, w_ren, done, out_if.out_valid} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {new_trans, new_sample_req, update_pos, w_ren, done, out_if.out_valid});
    end
    n_tests++;
    if (w_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_waddr: got %0d want 0", w_addr);
    end
    n_tests++;
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {out_if.out_pixel, out_if.out_x, out_if.out_y});
    end
    n_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({new_trans, new_sample_req, w_ren, done, out_if.out_valid} !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b want 00000",
               {new_trans, new_sample_req, w_ren, done, out_if.out_valid});
    end
  endtask

  task automatic test_centre();
    logic nt, upd, dn;
    int t_req, t_out;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(0, 1'b1);
    pix_m[1][1] = 77;
    fill_wt(0, 1'b0);
    wt_m[4] = 255;
    pack_window();
    push_expected(3, 5, 7);
    start_frame(3, nt);
    n_tests++;
    if (nt !== 1'b1) begin n_fail++; $display("FAIL centre_new_trans: got %b want 1", nt); end
    @(negedge clk);
    n_tests++;
    if (new_trans !== 1'b0) begin n_fail++; $display("FAIL centre_trans_pulse: got %b want 0", new_trans); end
    serve_window(5, 7, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL centre_timeout: got timeout want out_valid"); return; end
    n_tests++;
    if (t_out - t_req !== 12) begin n_fail++; $display("FAIL centre_latency: got %0d want 12", t_out - t_req); end
    n_tests++;
    e = sb.pop_front();
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
      n_fail++;
      $display("FAIL centre_out: got pix %0d (%0d,%0d) want %0d (%0d,%0d)", out_if.out_pixel,
               out_if.out_x, out_if.out_y, e.pix, e.x, e.y);
    end
    n_tests++;
    if (out_if.out_pixel !== 8'd77) begin n_fail++; $display("FAIL centre_77: got %0d want 77", out_if.out_pixel); end
    accept_out(upd, dn);
    n_tests++;
    if ({upd, dn} !== 2'b01) begin n_fail++; $display("FAIL centre_done: got upd/done %b want 01", {upd, dn}); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL centre_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_average();
    logic nt, upd, dn;
    int t_req, t_out, seq_bad;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(100, 1'b0);
    fill_wt(28, 1'b0);
    wt_m[8] = 32;
    pack_window();
    push_expected(3, 2, 3);
    start_frame(3, nt);
    serve_window(2, 3, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL avg_timeout: got timeout want out_valid"); return; end
    n_tests++;
    e = sb.pop_front();
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e || out_if.out_pixel !== 8'd100) begin
      n_fail++;
      $display("FAIL avg_out: got pix %0d (%0d,%0d) want %0d (%0d,%0d)", out_if.out_pixel,
               out_if.out_x, out_if.out_y, e.pix, e.x, e.y);
    end
    seq_bad = (addr_log.size() != 9) ? 1 : 0;
    for (int i = 0; i < addr_log.size() && i < 9; i++) if (addr_log[i] != i) seq_bad++;
    n_tests++;
    if (seq_bad !== 0) begin
      n_fail++;
      $display("FAIL avg_waddr_seq: got %0d taps with %0d errors want 0..8", addr_log.size(), seq_bad);
    end
    n_tests++;
    if (bad_addr !== 0) begin n_fail++; $display("FAIL waddr_idle: got %0d nonzero want 0", bad_addr); end
    accept_out(upd, dn);
  endtask

  task automatic test_round();
    logic nt, upd, dn;
    int t_req, t_out;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(0, 1'b1);
    pix_m[0][0] = 3;
    fill_wt(255, 1'b1);
    wt_m[0] = 128;
    pack_window();
    push_expected(1, 0, 59);
    start_frame(1, nt);
    serve_window(0, 59, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL round_timeout: got timeout want out_valid"); return; end
    n_tests++;
    if (t_out - t_req !== 4) begin n_fail++; $display("FAIL round_latency: got %0d want 4", t_out - t_req); end
    n_tests++;
    e = sb.pop_front();
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e || out_if.out_pixel !== 8'd2) begin
      n_fail++;
      $display("FAIL round_out: got pix %0d (%0d,%0d) want %0d (%0d,%0d)", out_if.out_pixel,
               out_if.out_x, out_if.out_y, e.pix, e.x, e.y);
    end
    accept_out(upd, dn);
  endtask

  task automatic test_saturate();
    logic nt, upd, dn;
    int t_req, t_out;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(255, 1'b0);
    fill_wt(255, 1'b0);
    pack_window();
    push_expected(5, 33, 44);
    start_frame(5, nt);
    serve_window(33, 44, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL sat_timeout: got timeout want out_valid"); return; end
    n_tests++;
    if (t_out - t_req !== 28) begin n_fail++; $display("FAIL sat_latency: got %0d want 28", t_out - t_req); end
    n_tests++;
    e = sb.pop_front();
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e || out_if.out_pixel !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_out: got pix %0d (%0d,%0d) want %0d (%0d,%0d)", out_if.out_pixel,
               out_if.out_x, out_if.out_y, e.pix, e.x, e.y);
    end
    accept_out(upd, dn);
  endtask

  task automatic test_clamp();
    logic nt, upd, dn;
    int t_req, t_out;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(0, 1'b1);
    fill_wt(255, 1'b1);
    pack_window();
    push_expected(1, 1, 1);
    start_frame(0, nt);
    serve_window(1, 1, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to || addr_log.size() != 1 || t_out - t_req != 4) begin
      n_fail++;
      $display("FAIL clamp_k0: got taps %0d latency %0d want taps 1 latency 4", addr_log.size(),
               t_out - t_req);
    end
    if (!to) begin
      e = sb.pop_front();
      n_tests++;
      if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
        n_fail++;
        $display("FAIL clamp_k0_out: got pix %0d want %0d", out_if.out_pixel, e.pix);
      end
      accept_out(upd, dn);
      @(negedge clk);
    end
    addr_log.delete();
    fill_wt(15, 1'b1);
    push_expected(31, 9, 8);
    start_frame(200, nt);
    serve_window(9, 8, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to || addr_log.size() != 961 || t_out - t_req != 964) begin
      n_fail++;
      $display("FAIL clamp_kmax: got taps %0d latency %0d want taps 961 latency 964",
               addr_log.size(), t_out - t_req);
      return;
    end
    e = sb.pop_front();
    n_tests++;
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
      n_fail++;
      $display("FAIL clamp_kmax_out: got pix %0d want %0d", out_if.out_pixel, e.pix);
    end
    accept_out(upd, dn);
  endtask

  task automatic test_back_to_back();
    logic nt, upd, dn;
    int t_req, t_out;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(0, 1'b1);
    fill_wt(40, 1'b1);
    pack_window();
    push_expected(3, 10, 11);
    start_frame(3, nt);
    serve_window(10, 11, 1'b0, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL b2b_timeout1: got timeout want out_valid"); return; end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({out_if.out_valid, update_pos} !== 2'b10 ||
          {out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got valid %b upd %b pix %0d (%0d,%0d) want 1 0 %0d (%0d,%0d)",
                 i, out_if.out_valid, update_pos, out_if.out_pixel, out_if.out_x, out_if.out_y,
                 e.pix, e.x, e.y);
      end
      @(negedge clk);
    end
    accept_out(upd, dn);
    n_tests++;
    if ({upd, dn} !== 2'b10) begin n_fail++; $display("FAIL b2b_update: got upd/done %b want 10", {upd, dn}); end
    // start and a new kernel_size mid-frame must both be ignored.
    kernel_size = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (new_trans !== 1'b0) begin n_fail++; $display("FAIL b2b_start_ignored: got %b want 0", new_trans); end
    fill_pix(0, 1'b1);
    pack_window();
    push_expected(3, 12, 13);
    serve_window(12, 13, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to || t_out - t_req != 12 || addr_log.size() != 18) begin
      n_fail++;
      $display("FAIL b2b_second: got latency %0d taps %0d want 12 18", t_out - t_req,
               addr_log.size());
      return;
    end
    e = sb.pop_front();
    n_tests++;
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
      n_fail++;
      $display("FAIL b2b_out2: got pix %0d (%0d,%0d) want %0d (%0d,%0d)", out_if.out_pixel,
               out_if.out_x, out_if.out_y, e.pix, e.x, e.y);
    end
    accept_out(upd, dn);
    n_tests++;
    if ({upd, dn} !== 2'b01) begin n_fail++; $display("FAIL b2b_done: got upd/done %b want 01", {upd, dn}); end
  endtask

  task automatic test_mid_reset();
    logic nt, upd, dn;
    int t_req, t_out, seen;
    bit to;
    exp_t e;
    hard_reset();
    fill_pix(0, 1'b1);
    fill_wt(255, 1'b1);
    pack_window();
    start_frame(5, nt);
    new_sample_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 64 && seen == 0; i++) begin
      @(negedge clk);
      if (new_sample_req) seen = 1;
    end
    new_sample_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (seen != 1 || w_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_mac: got req %0d w_ren %b want 1 1", seen, w_ren);
    end
    n_rst = 1'b0;
    #1;
    n_tests++;
    if ({new_trans, new_sample_req, update_pos, w_ren, done, out_if.out_valid, w_addr,
         out_if.out_pixel, out_if.out_x, out_if.out_y} !== 36'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ctl %b w_addr %0d want all 0",
               {new_trans, new_sample_req, update_pos, w_ren, done, out_if.out_valid}, w_addr);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({new_trans, w_ren, done, out_if.out_valid} !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_idle: got %b want 0000", {new_trans, w_ren, done, out_if.out_valid});
    end
    push_expected(3, 4, 4);
    start_frame(3, nt);
    n_tests++;
    if (nt !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got %b want 1", nt); end
    serve_window(4, 4, 1'b1, t_req, t_out, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL midrst_timeout: got timeout want out_valid"); return; end
    e = sb.pop_front();
    n_tests++;
    if ({out_if.out_pixel, out_if.out_x, out_if.out_y} !== e) begin
      n_fail++;
      $display("FAIL midrst_out: got pix %0d want %0d", out_if.out_pixel, e.pix);
    end
    accept_out(upd, dn);
    n_tests++;
    if (dn !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b want 1", dn); end
  endtask

  initial begin
    n_rst = 1'b1;
    start = 1'b0;
    kernel_size = 8'd0;
    new_sample_ready = 1'b0;
    working_memory = '0;
    curr_x = 6'd0;
    curr_y = 6'd0;
    end_pos = 1'b0;
    out_if.out_ready = 1'b0;
    test_reset();
    test_centre();
    test_average();
    test_round();
    test_saturate();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary after 50000 cycles want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
